if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS CPU. It is the producer side of the control-unit interface: it holds the PC, reads the instruction memory and loads the IF/ID pipeline register.
- It presents opCode (instr[31:26]) and the full instruction word to the ID stage, where ctr decodes them.
- It handles sequential fetch, hazard stalls, taken branches, jumps, and bubble insertion.

---
 rtl/if_stage.sv | 77 +++++++
 tb/tb_if_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Brief   : MIPS instruction-fetch stage: PC, imem address, IF/ID register.
// Revision: 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    input  logic        jump,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] pc,
    output logic [31:0] ifIdInstr,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid,
    output logic [5:0]  opCode,
    output logic [15:0] fetchCount
);

    localparam logic [31:0] c_RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;
    logic [15:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_jump_target   = {r_if_id_pc_plus4[31:28], r_if_id_instr[25:0], 2'b00};
    assign w_branch_target = {branchTarget[31:2], 2'b00};

    // Redirects beat stall; branch beats jump since it belongs to the older instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= c_RESET_PC_ALIGNED;
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_pc_plus4 <= 32'h0000_0000;
            r_if_id_valid    <= 1'b0;
            r_fetch_count    <= 16'h0000;
        end else if (branchTaken) begin
            r_pc          <= w_branch_target;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (jump) begin
            r_pc          <= w_jump_target;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (!stall) begin
            r_pc             <= w_pc_plus4;
            r_if_id_instr    <= imemData;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b1;
            r_fetch_count    <= r_fetch_count + 16'd1;
        end
    end

    assign imemAddr    = r_pc;
    assign pc          = r_pc;
    assign ifIdInstr   = r_if_id_instr;
    assign ifIdPcPlus4 = r_if_id_pc_plus4;
    assign ifIdValid   = r_if_id_valid;
    assign opCode      = r_if_id_instr[31:26];
    assign fetchCount  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage
// Brief   : Self-checking bench for if_stage with an expected-state scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] pc;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic [5:0]  opCode;
    logic [15:0] fetchCount;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic        m_valid;
    logic [15:0] m_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .jump         (jump),
        .imemAddr     (imemAddr),
        .imemData     (imemData),
        .pc           (pc),
        .ifIdInstr    (ifIdInstr),
        .ifIdPcPlus4  (ifIdPcPlus4),
        .ifIdValid    (ifIdValid),
        .opCode       (opCode),
        .fetchCount   (fetchCount)
    );

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem_f = 32'h012A_4020;
            32'h0000_0004: imem_f = 32'h8C08_0004;
            32'h0000_0008: imem_f = 32'hAC08_0008;
            32'h0000_000C: imem_f = 32'h1000_0003;
            32'h0000_0010: imem_f = 32'h0800_0040;
            default:       imem_f = {6'b001000, a[27:2]};
        endcase
    endfunction

    always_comb imemData = imem_f(imemAddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic check_state(input exp_t e);
        chk("pc",          pc,                  e.pc);
        chk("imemAddr",    imemAddr,            e.pc);
        chk("ifIdInstr",   ifIdInstr,           e.instr);
        chk("opCode",      {26'd0, opCode},     {26'd0, e.instr[31:26]});
        chk("ifIdPcPlus4", ifIdPcPlus4,         e.pp4);
        chk("ifIdValid",   {31'd0, ifIdValid},  {31'd0, e.valid});
        chk("fetchCount",  {16'd0, fetchCount}, {16'd0, e.cnt});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
    endtask

    // Drive one cycle at a negedge, predict the post-edge state, check after the edge.
    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic j);
        exp_t e;
        stall = s; branchTaken = b; branchTarget = t; jump = j;
        if (b) begin
            m_pc = {t[31:2], 2'b00}; m_instr = 32'h0; m_valid = 1'b0;
        end else if (j) begin
            m_pc = {m_pp4[31:28], m_instr[25:0], 2'b00}; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!s) begin
            m_instr = imem_f(m_pc); m_pp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            m_valid = 1'b1; m_cnt = m_cnt + 16'd1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            check_state(sb.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t r;
        rst_n = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0; jump = 1'b0;
        model_reset();
        r.pc = 32'h0; r.instr = 32'h0; r.pp4 = 32'h0; r.valid = 1'b0; r.cnt = 16'h0;
        #12;
        check_state(r);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch up to lw in IF/ID, then a 3-cycle stall.
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        repeat (3) step(1, 0, 32'h0, 0);
        // Release: sw, beq, j follow.
        repeat (3) step(0, 0, 32'h0, 0);
        // j 0x40 with ifIdPcPlus4=0x14 redirects to 0x100.
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 0);
        // Branch + jump + stall together: branch wins.
        step(1, 1, 32'h0000_0200, 1);
        step(0, 0, 32'h0, 0);
        // Jump + stall: jump wins.
        step(1, 0, 32'h0, 1);
        // Misaligned target is forced aligned; then wrap at the top of memory.
        step(0, 1, 32'hFFFF_FFFF, 0);
        step(0, 0, 32'h0, 0);
        repeat (8) step(0, 0, 32'h0, 0);

        // Async reset between edges, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb.delete();
        check_state(r);
        @(negedge clk);
        rst_n = 1'b1;

        // Drive fetchCount through 0xFFFF and back to 0x0000.
        repeat (65535) step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
